fight_referee: RTL

Round controller and hit arbiter for the two-player fighter. Sits between the `player` instances and the color mapper/HUD. It consumes both players' positions, actions and facing. It sequences each round (idle → countdown → fight → KO), holds both players in reset outside live play, resolves punches into damage with per-player cooldown, and publishes health, game state and winner.

---
 rtl/fight_referee.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/fight_referee.sv
// fight_referee: round sequencer (idle/countdown/fight/KO) and punch arbiter for the two-player fighter.
// Define REFEREE_BLOCK_EN to halve damage against a defender holding BLOCK_ACT.
module fight_referee #(
  parameter logic [9:0] MAX_HEALTH   = 10'd100,
  parameter logic [9:0] DAMAGE       = 10'd10,
  parameter logic [9:0] REACH        = 10'd80,
  parameter logic [9:0] PUNCH_ACT    = 10'd13,
  parameter logic [9:0] BLOCK_ACT    = 10'd15,
  parameter logic [7:0] HIT_COOLDOWN = 8'd30,
  parameter logic [7:0] START_DELAY  = 8'd120,
  parameter logic [7:0] KO_DELAY     = 8'd180
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       start,
  input  logic [9:0] p1x,
  input  logic [9:0] p2x,
  input  logic [9:0] action1,
  input  logic [9:0] action2,
  input  logic [9:0] direction1,
  input  logic [9:0] direction2,
  output logic [9:0] health1,
  output logic [9:0] health2,
  output logic [1:0] game_state,
  output logic       players_reset,
  output logic [1:0] winner,
  output logic       hit1,
  output logic       hit2
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_FIGHT = 2'd2,
    S_KO    = 2'd3
  } state_t;

`ifdef REFEREE_BLOCK_EN
  localparam logic BLOCK_EN = 1'b1;
`else
  localparam logic BLOCK_EN = 1'b0;
`endif

  state_t     r_state, w_state_nxt;
  logic [7:0] r_timer, w_timer_nxt;
  logic [7:0] r_cool1, r_cool2, w_cool1_nxt, w_cool2_nxt, w_cool1_eff, w_cool2_eff;
  logic [9:0] r_h1, r_h2, w_h1_nxt, w_h2_nxt;
  logic [1:0] r_win, w_win_nxt;
  logic       r_hit1, r_hit2, w_hit1_nxt, w_hit2_nxt;
  logic       r_players_reset;
  logic       r_frame_d, r_tick;
  logic [9:0] w_dist;
  logic       w_faced1, w_faced2, w_land1, w_land2, w_blk1, w_blk2;

  function automatic logic [9:0] sat_sub(input logic [9:0] h, input logic [9:0] d);
    return (h > d) ? (h - d) : 10'd0;
  endfunction

  function automatic logic [9:0] hit_damage(input logic blocked);
    return blocked ? (DAMAGE >> 1) : DAMAGE;
  endfunction

  function automatic logic [7:0] cool_dec(input logic [7:0] c);
    return (c != 8'd0) ? (c - 8'd1) : 8'd0;
  endfunction

  // Frame-tick edge detect: r_tick is high for one Clk, one Clk after frame_clk rises
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_frame_d <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_frame_d <= frame_clk;
      r_tick    <= frame_clk & ~r_frame_d;
    end
  end

  assign w_dist   = (p1x >= p2x) ? (p1x - p2x) : (p2x - p1x);
  assign w_faced1 = ((direction1 == 10'd1) && (p2x >= p1x)) || ((direction1 == 10'd0) && (p1x >= p2x));
  assign w_faced2 = ((direction2 == 10'd1) && (p1x >= p2x)) || ((direction2 == 10'd0) && (p2x >= p1x));
  // Cooldown gate sees this tick's decremented value, so landings repeat every HIT_COOLDOWN ticks
  assign w_cool1_eff = cool_dec(r_cool1);
  assign w_cool2_eff = cool_dec(r_cool2);
  assign w_land1  = (action1 == PUNCH_ACT) && (w_cool1_eff == 8'd0) && w_faced1 && (w_dist <= REACH);
  assign w_land2  = (action2 == PUNCH_ACT) && (w_cool2_eff == 8'd0) && w_faced2 && (w_dist <= REACH);
  assign w_blk1   = BLOCK_EN & (action1 == BLOCK_ACT);
  assign w_blk2   = BLOCK_EN & (action2 == BLOCK_ACT);

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_cool1_nxt = r_cool1;
    w_cool2_nxt = r_cool2;
    w_h1_nxt    = r_h1;
    w_h2_nxt    = r_h2;
    w_win_nxt   = r_win;
    w_hit1_nxt  = 1'b0;
    w_hit2_nxt  = 1'b0;
    if (r_tick) begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            w_state_nxt = S_COUNT;
            w_timer_nxt = 8'd0;
            w_h1_nxt    = MAX_HEALTH;
            w_h2_nxt    = MAX_HEALTH;
            w_win_nxt   = 2'd0;
          end
        end
        S_COUNT: begin
          if (r_timer == START_DELAY - 8'd1) begin
            w_state_nxt = S_FIGHT;
            w_timer_nxt = 8'd0;
            w_cool1_nxt = 8'd0;
            w_cool2_nxt = 8'd0;
          end else begin
            w_timer_nxt = r_timer + 8'd1;
          end
        end
        S_FIGHT: begin
          w_cool1_nxt = w_cool1_eff;
          w_cool2_nxt = w_cool2_eff;
          if (w_land1) begin
            w_h2_nxt    = sat_sub(r_h2, hit_damage(w_blk2));
            w_cool1_nxt = HIT_COOLDOWN;
            w_hit1_nxt  = 1'b1;
          end
          if (w_land2) begin
            w_h1_nxt    = sat_sub(r_h1, hit_damage(w_blk1));
            w_cool2_nxt = HIT_COOLDOWN;
            w_hit2_nxt  = 1'b1;
          end
          // winner encodes {P1 down, P2 down}: 1 = P1 wins, 2 = P2 wins, 3 = draw
          if ((w_h1_nxt == 10'd0) || (w_h2_nxt == 10'd0)) begin
            w_state_nxt = S_KO;
            w_timer_nxt = 8'd0;
            w_win_nxt   = {(w_h1_nxt == 10'd0), (w_h2_nxt == 10'd0)};
          end
        end
        S_KO: begin
          if (r_timer == KO_DELAY - 8'd1) begin
            w_state_nxt = S_IDLE;
            w_timer_nxt = 8'd0;
          end else begin
            w_timer_nxt = r_timer + 8'd1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state         <= S_IDLE;
      r_timer         <= 8'd0;
      r_cool1         <= 8'd0;
      r_cool2         <= 8'd0;
      r_h1            <= MAX_HEALTH;
      r_h2            <= MAX_HEALTH;
      r_win           <= 2'd0;
      r_hit1          <= 1'b0;
      r_hit2          <= 1'b0;
      r_players_reset <= 1'b1;
    end else begin
      r_state         <= w_state_nxt;
      r_timer         <= w_timer_nxt;
      r_cool1         <= w_cool1_nxt;
      r_cool2         <= w_cool2_nxt;
      r_h1            <= w_h1_nxt;
      r_h2            <= w_h2_nxt;
      r_win           <= w_win_nxt;
      r_hit1          <= w_hit1_nxt;
      r_hit2          <= w_hit2_nxt;
      r_players_reset <= (w_state_nxt != S_FIGHT);
    end
  end

  assign health1       = r_h1;
  assign health2       = r_h2;
  assign game_state    = r_state;
  assign players_reset = r_players_reset;
  assign winner        = r_win;
  assign hit1          = r_hit1;
  assign hit2          = r_hit2;

endmodule
